// File: rtl/nco_phase_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nco_phase_gen: phase accumulator producing z0/x0/y0 for a cos/sin CORDIC.
// Rev 1.0
// ----------------------------------------------------------------------------
module nco_phase_gen #(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 32,
   parameter int LATENCY   = 17,
   parameter int AMPLITUDE = 19898
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clear,
   input  logic [ACC_WIDTH-1:0] fcw,
   input  logic                 fcw_valid,
   output logic                 fcw_ready,
   input  logic [WIDTH-1:0]     phase_off,
   output logic [WIDTH-1:0]     x0,
   output logic [WIDTH-1:0]     y0,
   output logic [WIDTH-1:0]     z0,
   output logic                 phase_valid,
   output logic                 out_valid
);

   localparam logic [WIDTH-1:0] c_amp = WIDTH'(AMPLITUDE);

   localparam logic [1:0] c_ld_empty = 2'd0;
   localparam logic [1:0] c_ld_full  = 2'd1;
   localparam logic [1:0] c_ld_drain = 2'd2;

   logic [1:0]           ld_state_q, ld_state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] fcw_act_q, fcw_act_d;
   logic [ACC_WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0]     z0_q, z0_d;
   logic [WIDTH-1:0]     x0_q, x0_d;
   logic [WIDTH-1:0]     y0_q, y0_d;
   logic                 phase_valid_q, phase_valid_d;
   logic [LATENCY-1:0]   vpipe_q, vpipe_d;

   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_carry;
   logic                 w_commit_cond;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_commit;

   assign w_sum   = {1'b0, acc_q} + {1'b0, fcw_act_q};
   assign w_carry = w_sum[ACC_WIDTH];

   // A pending word may only land where it cannot tear the phase: at a wrap,
   // when the accumulator is idle or stuck at zero step, or on a clear.
   assign w_commit_cond = clear || (en && w_carry) || !en || (fcw_act_q == '0);

   // Load-handshake FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_state_q <= c_ld_empty;
      end else begin
         ld_state_q <= ld_state_d;
      end
   end

   // Load-handshake FSM: next state (DRAIN holds ready low one extra cycle)
   always_comb begin
      ld_state_d = ld_state_q;
      case (ld_state_q)
         c_ld_empty: if (fcw_valid)     ld_state_d = c_ld_full;
         c_ld_full:  if (w_commit_cond) ld_state_d = c_ld_drain;
         c_ld_drain:                    ld_state_d = c_ld_empty;
         default:                       ld_state_d = c_ld_empty;
      endcase
   end

   // Load-handshake FSM: outputs
   always_comb begin
      w_ready  = 1'b0;
      w_accept = 1'b0;
      w_commit = 1'b0;
      case (ld_state_q)
         c_ld_empty: begin
            w_ready  = 1'b1;
            w_accept = fcw_valid;
         end
         c_ld_full: w_commit = w_commit_cond;
         default: ;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = w_sum[ACC_WIDTH-1:0];
      end
      fcw_act_d     = w_commit ? pend_q : fcw_act_q;
      pend_d        = w_accept ? fcw : pend_q;
      z0_d          = acc_q[ACC_WIDTH-1 -: WIDTH] + phase_off;
      phase_valid_d = en && !clear;
      x0_d          = c_amp;
      y0_d          = '0;
   end

   generate
      if (LATENCY == 1) begin : g_pipe_single
         always_comb begin
            vpipe_d = clear ? 1'b0 : phase_valid_q;
         end
      end else begin : g_pipe_shift
         always_comb begin
            vpipe_d = clear ? '0 : {vpipe_q[LATENCY-2:0], phase_valid_q};
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q         <= '0;
         fcw_act_q     <= '0;
         pend_q        <= '0;
         z0_q          <= '0;
         x0_q          <= c_amp;
         y0_q          <= '0;
         phase_valid_q <= 1'b0;
         vpipe_q       <= '0;
      end else begin
         acc_q         <= acc_d;
         fcw_act_q     <= fcw_act_d;
         pend_q        <= pend_d;
         z0_q          <= z0_d;
         x0_q          <= x0_d;
         y0_q          <= y0_d;
         phase_valid_q <= phase_valid_d;
         vpipe_q       <= vpipe_d;
      end
   end

   assign fcw_ready   = w_ready;
   assign x0          = x0_q;
   assign y0          = y0_q;
   assign z0          = z0_q;
   assign phase_valid = phase_valid_q;
   assign out_valid   = vpipe_q[LATENCY-1];

endmodule
`default_nettype wire
